// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction from ID, pipeline control, MEM/WB
// forwarding sources, and the forwarded operands going into the ALU.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  // ID side
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [3:0]    id_aluco;
  logic          id_alusrc;
  logic [RW-1:0] id_wdest;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic          id_memtoreg;
  // pipeline control
  logic          stall;
  logic          flush;
  // forwarding sources
  logic          mem_regwrite;
  logic [RW-1:0] mem_rd;
  logic [DW-1:0] mem_result;
  logic          wb_regwrite;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_result;
  // EX side
  logic [DW-1:0] aluin1;
  logic [DW-1:0] aluin2;
  logic [3:0]    aluco;
  logic          ex_valid;
  logic [RW-1:0] ex_wdest;
  logic [DW-1:0] ex_store_data;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_memtoreg;
  logic          hazard_stall;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_data, id_rt_data, id_imm, id_aluco,
           id_alusrc, id_wdest, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           stall, flush, mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    input  aluin1, aluin2, aluco, ex_valid, ex_wdest, ex_store_data,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, hazard_stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_data, id_rt_data, id_imm, id_aluco,
           id_alusrc, id_wdest, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           stall, flush, mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    output aluin1, aluin2, aluco, ex_valid, ex_wdest, ex_store_data,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding from MEM/WB and
// load-use hazard detection (stalls ID, injects a bubble into EX).
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  id_ex_stage_if.slave   bus
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [3:0]    aluco;
    logic          alusrc;
    logic [RW-1:0] wdest;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } ex_regs_t;

  ex_regs_t      ex_q;
  ex_regs_t      ex_d;
  logic          hazard;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_t;

  // Load-use hazard: a load in EX whose destination is read by ID.
  always_comb begin
    hazard = bus.id_valid & ex_q.valid & ex_q.memread & (ex_q.wdest != '0)
           & ((ex_q.wdest == bus.id_rs) | (ex_q.wdest == bus.id_rt));
  end

  // Next EX contents: flush beats stall beats load-use bubble beats capture.
  // A bubble clears everything, including rs/rt, which also disables forwarding
  // so the ALU operands sit at a stable zero.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.stall) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = bus.id_valid;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.rs_data  = bus.id_rs_data;
      ex_d.rt_data  = bus.id_rt_data;
      ex_d.imm      = bus.id_imm;
      ex_d.aluco    = bus.id_aluco;
      ex_d.alusrc   = bus.id_alusrc;
      ex_d.wdest    = bus.id_wdest;
      ex_d.regwrite = bus.id_regwrite & bus.id_valid;
      ex_d.memread  = bus.id_memread  & bus.id_valid;
      ex_d.memwrite = bus.id_memwrite & bus.id_valid;
      ex_d.memtoreg = bus.id_memtoreg & bus.id_valid;
    end
  end

  // Stage register; async reset drops whatever was in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand forwarding: MEM is younger than WB so it wins; r0 never forwards.
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == ex_q.rs)) begin
      fwd_a = bus.mem_result;
    end else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == ex_q.rs)) begin
      fwd_a = bus.wb_result;
    end

    fwd_t = ex_q.rt_data;
    if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == ex_q.rt)) begin
      fwd_t = bus.mem_result;
    end else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == ex_q.rt)) begin
      fwd_t = bus.wb_result;
    end
  end

  // Store data always takes the forwarded rt, regardless of alusrc.
  assign bus.aluin1        = fwd_a;
  assign bus.aluin2        = ex_q.alusrc ? ex_q.imm : fwd_t;
  assign bus.ex_store_data = fwd_t;
  assign bus.aluco         = ex_q.aluco;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_wdest      = ex_q.wdest;
  assign bus.ex_regwrite   = ex_q.regwrite;
  assign bus.ex_memread    = ex_q.memread;
  assign bus.ex_memwrite   = ex_q.memwrite;
  assign bus.ex_memtoreg   = ex_q.memtoreg;
  assign bus.hazard_stall  = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic,
// every cycle compared against a record-level model of the instruction in EX.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  id_ex_stage_if #(.DW(32), .RW(5)) bus ();

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, wdest;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  aluco;
    logic        alusrc, rw, mr, mw, mt;
  } ex_model_t;

  ex_model_t m;

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] regd);
    if (bus.mem_regwrite && bus.mem_rd != 5'd0 && bus.mem_rd == src) return bus.mem_result;
    if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == src) return bus.wb_result;
    return regd;
  endfunction

  function automatic logic exp_hazard();
    return bus.id_valid && m.valid && m.mr && m.wdest != 5'd0 &&
           (m.wdest == bus.id_rs || m.wdest == bus.id_rt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and move the model the way the EX record should move.
  task automatic tick();
    logic haz;
    haz = exp_hazard();
    @(posedge clk);
    if (!rst_n || bus.flush || (!bus.stall && haz)) begin
      m = '{default: '0};
    end else if (!bus.stall) begin
      m.valid = bus.id_valid;
      m.rs = bus.id_rs; m.rt = bus.id_rt; m.wdest = bus.id_wdest;
      m.rsd = bus.id_rs_data; m.rtd = bus.id_rt_data; m.imm = bus.id_imm;
      m.aluco = bus.id_aluco; m.alusrc = bus.id_alusrc;
      m.rw = bus.id_regwrite & bus.id_valid;
      m.mr = bus.id_memread & bus.id_valid;
      m.mw = bus.id_memwrite & bus.id_valid;
      m.mt = bus.id_memtoreg & bus.id_valid;
    end
    #1;
  endtask

  task automatic check_all();
    logic [31:0] ea, et;
    #1;
    ea = fwd(m.rs, m.rsd);
    et = fwd(m.rt, m.rtd);
    chk("aluin1", bus.aluin1, ea);
    chk("aluin2", bus.aluin2, m.alusrc ? m.imm : et);
    chk("store_data", bus.ex_store_data, et);
    chk("aluco", 32'(bus.aluco), 32'(m.aluco));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    chk("ex_wdest", 32'(bus.ex_wdest), 32'(m.wdest));
    chk("ex_regwrite", 32'(bus.ex_regwrite), 32'(m.rw));
    chk("ex_memread", 32'(bus.ex_memread), 32'(m.mr));
    chk("ex_memwrite", 32'(bus.ex_memwrite), 32'(m.mw));
    chk("ex_memtoreg", 32'(bus.ex_memtoreg), 32'(m.mt));
    chk("hazard_stall", 32'(bus.hazard_stall), 32'(exp_hazard()));
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [3:0] co, input logic src, input logic [4:0] wd,
                        input logic rw, input logic mr, input logic mw, input logic mt);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_aluco = co; bus.id_alusrc = src; bus.id_wdest = wd;
    bus.id_regwrite = rw; bus.id_memread = mr; bus.id_memwrite = mw; bus.id_memtoreg = mt;
  endtask

  task automatic fwd_off();
    bus.mem_regwrite = 1'b0; bus.mem_rd = 5'd0; bus.mem_result = 32'd0;
    bus.wb_regwrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_result = 32'd0;
  endtask

  task automatic randomize_inputs();
    set_id(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    bus.stall = ($urandom_range(0, 7) == 0);
    bus.flush = ($urandom_range(0, 9) == 0);
    bus.mem_regwrite = 1'($urandom); bus.mem_rd = 5'($urandom_range(0, 3));
    bus.mem_result = $urandom;
    bus.wb_regwrite = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 3));
    bus.wb_result = $urandom;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m = '{default: '0};

    // T1: reset with arbitrary inputs
    rst_n = 1'b0;
    randomize_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0;
    check_all();
    tick();
    check_all();
    chk("t1_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("t1_aluco", 32'(bus.aluco), 32'd0);
    chk("t1_aluin1", bus.aluin1, 32'd0);
    chk("t1_aluin2", bus.aluin2, 32'd0);
    chk("t1_hazard", 32'(bus.hazard_stall), 32'd0);
    rst_n = 1'b1;
    fwd_off();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // T2: plain capture, SUB 8 - 4
    set_id(1, 5'd1, 5'd2, 32'd8, 32'd4, 32'd0, 4'd6, 0, 5'd3, 1, 0, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all();
    chk("t2_aluin1", bus.aluin1, 32'd8);
    chk("t2_aluin2", bus.aluin2, 32'd4);
    chk("t2_aluco", 32'(bus.aluco), 32'd6);

    // T3: forwarding priority on rs=3
    set_id(1, 5'd3, 5'd4, 32'h11, 32'h22, 32'd0, 4'd2, 0, 5'd0, 0, 0, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_regwrite = 1; bus.mem_rd = 5'd3; bus.mem_result = 32'h55;
    bus.wb_regwrite = 1; bus.wb_rd = 5'd3; bus.wb_result = 32'h77;
    check_all();
    chk("t3_mem_prio", bus.aluin1, 32'h55);
    bus.mem_regwrite = 0;
    check_all();
    chk("t3_wb_fwd", bus.aluin1, 32'h77);
    bus.mem_regwrite = 1; bus.mem_rd = 5'd0;
    check_all();
    chk("t3_mem_r0", bus.aluin1, 32'h77);
    bus.wb_rd = 5'd0;
    #1;
    chk("t3_no_fwd", bus.aluin1, 32'h11);
    fwd_off();
    tick();

    // T4: LW r5 followed by ADD reading r5
    set_id(1, 5'd1, 5'd0, 32'h100, 32'd0, 32'd4, 4'd2, 1, 5'd5, 1, 1, 0, 1);
    tick();
    set_id(1, 5'd6, 5'd5, 32'h20, 32'h30, 32'd0, 4'd2, 0, 5'd7, 1, 0, 0, 0);
    check_all();
    chk("t4_hazard", 32'(bus.hazard_stall), 32'd1);
    tick();
    check_all();
    chk("t4_bubble", 32'(bus.ex_valid), 32'd0);
    chk("t4_hazard_clr", 32'(bus.hazard_stall), 32'd0);
    tick();
    check_all();
    chk("t4_add_valid", 32'(bus.ex_valid), 32'd1);
    chk("t4_add_wdest", 32'(bus.ex_wdest), 32'd7);

    // T5: stall holds, flush beats stall
    set_id(1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd0, 4'd1, 0, 5'd8, 1, 0, 0, 0);
    tick();
    bus.stall = 1'b1;
    set_id(1, 5'd2, 5'd0, 32'h99, 32'd0, 32'd0, 4'd0, 0, 5'd9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_all();
      chk("t5_hold", bus.aluin1, 32'h10);
      tick();
    end
    check_all();
    bus.flush = 1'b1;
    tick();
    check_all();
    chk("t5_flush", 32'(bus.ex_valid), 32'd0);
    chk("t5_flush_rw", 32'(bus.ex_regwrite), 32'd0);
    bus.stall = 1'b0; bus.flush = 1'b0;

    // T6: immediate operand with forwarded rt for the store
    set_id(1, 5'd1, 5'd4, 32'd0, 32'd3, 32'hFFFF_FFFC, 4'd2, 1, 5'd0, 0, 0, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_regwrite = 1; bus.mem_rd = 5'd4; bus.mem_result = 32'd9;
    check_all();
    chk("t6_aluin2", bus.aluin2, 32'hFFFF_FFFC);
    chk("t6_store", bus.ex_store_data, 32'd9);
    fwd_off();

    // Random traffic with one async reset in the middle of a cycle
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      check_all();
      if (n == 200) begin
        rst_n = 1'b0;
        #1;
        m = '{default: '0};
        check_all();
        chk("async_rst_valid", 32'(bus.ex_valid), 32'd0);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
